// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, default timing parameters,
// host command bytes and the parity helper used by transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP
  } ps2_tx_state_t;

  localparam int INHIBIT_CYCLES_DEF = 10000;
  localparam int TIMEOUT_CYCLES_DEF = 2000000;
  localparam int FILTER_LEN_DEF     = 8;

  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  // PS/2 frames use odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Line conditioner shared by the PS/2 transmitter and receiver: synchronizes
// both lines, debounces the clock line and emits a pulse on each clean fall.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_tick
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  c_level;

  // The filtered level only flips once FILTER_LEN consecutive samples agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      hist      <= '1;
      c_level   <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      c_sync    <= {c_sync[0], ps2c};
      d_sync    <= {d_sync[0], ps2d};
      hist      <= {hist[FILTER_LEN-2:0], c_sync[1]};
      fall_tick <= 1'b0;
      if (c_level && (hist == '0)) begin
        c_level   <= 1'b0;
        fall_tick <= 1'b1;
      end else if (!c_level && (hist == '1)) begin
        c_level <= 1'b1;
      end
    end
  end

  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues the start bit,
// shifts out data and odd parity on device clock falls, then checks the ack.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_ps2,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int CNT_W = $clog2(max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [8:0]       shift, shift_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic             c_low, c_low_n;
  logic             d_low, d_low_n;
  logic             done_n, err_n;
  logic             ps2d_sync;
  logic             fall_tick;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .ps2d_sync(ps2d_sync),
    .fall_tick(fall_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      shift        <= '0;
      bit_cnt      <= '0;
      c_low        <= 1'b0;
      d_low        <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      shift        <= shift_n;
      bit_cnt      <= bit_cnt_n;
      c_low        <= c_low_n;
      d_low        <= d_low_n;
      tx_done_tick <= done_n;
      tx_err_tick  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ps2) begin
          shift_n = {odd_parity(din), din};
          cnt_n   = '0;
          state_n = RTS;
        end
      end
      RTS: begin
        if (cnt == INHIBIT_LAST) begin
          cnt_n   = '0;
          state_n = START;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      START, DATA, STOP: begin
        // Device clock falls restart the watchdog; a silent device aborts.
        if (fall_tick) begin
          cnt_n = '0;
          if (state == START) begin
            state_n   = DATA;
            bit_cnt_n = 4'd8;
          end else if (state == DATA) begin
            shift_n = {1'b0, shift[8:1]};
            if (bit_cnt == 4'd0) state_n = STOP;
            else                 bit_cnt_n = bit_cnt - 4'd1;
          end else begin
            state_n = IDLE;
            if (ps2d_sync) err_n  = 1'b1;
            else           done_n = 1'b1;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    c_low_n = (state_n == RTS);
    d_low_n = (state_n == START) || ((state_n == DATA) && !shift_n[0]);
  end

  assign ps2c    = c_low ? 1'b0 : 1'bz;
  assign ps2d    = d_low ? 1'b0 : 1'bz;
  assign tx_idle = (state == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx: a behavioural PS/2 device clocks frames out of
// the host while a monitor checks every done/error pulse against queued results.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int TO   = 5000;
  localparam int FL   = 8;
  localparam int HALF = 40;
  localparam int TICK_LAT = 2 + FL + 2;

  typedef struct {
    logic       is_err;
    logic       chk_frame;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       wr_ps2;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;

  logic       dev_c_low;
  logic       dev_d_low;
  logic [7:0] cap_byte;
  logic       cap_par;
  logic       cap_start;
  logic       cap_stop;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_ps2      (wr_ps2),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issue one write pulse and, if a pulse is expected, queue the result.
  task automatic applyStimulus(input logic [7:0] d, input bit expect_tick, input bit is_err,
                               input bit chk_frame, input logic par);
    exp_t e;
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    if (expect_tick) begin
      e.is_err    = is_err;
      e.chk_frame = chk_frame;
      e.data      = d;
      e.par       = par;
      exp_q.push_back(e);
    end
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device model: wait for request-to-send, then clock n_edges bits out of the host.
  task automatic deviceFrame(input int n_edges, input bit ack, input int glitch_edge,
                             output int last_fall);
    int t;
    int rts_len;
    last_fall = cyc;
    t = 0;
    while (ps2c !== 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checkOutput("rts_seen", {31'd0, ps2c}, 32'd0);
      return;
    end
    rts_len = 0;
    while (ps2c === 1'b0 && rts_len < 2000) begin
      rts_len++;
      @(negedge clk);
    end
    checkOutput("rts_len", rts_len, INH);
    t = 0;
    while (ps2d !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput("start_drive", {31'd0, ps2d}, 32'd0);
    repeat (HALF) @(negedge clk);
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 1)          cap_start = ps2d;
      if (k == 11 && ack)  dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      if (k == glitch_edge) begin
        repeat (10) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (3) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k <= 8)       cap_byte[k-1] = ps2d;
      else if (k == 9)  cap_par       = ps2d;
      else if (k == 10) cap_stop      = ps2d;
    end
    dev_d_low = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (tx_done_tick || tx_err_tick) begin
      checkOutput("tick_exclusive", {31'd0, tx_done_tick & tx_err_tick}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_tick: got done=%0b err=%0b, expected none",
                 tx_done_tick, tx_err_tick);
      end else begin
        e = exp_q.pop_front();
        checkOutput("tick_kind_err", {31'd0, tx_err_tick}, {31'd0, e.is_err});
        if (e.chk_frame) begin
          checkOutput("data_byte", {24'd0, cap_byte}, {24'd0, e.data});
          checkOutput("parity", {31'd0, cap_par}, {31'd0, e.par});
          checkOutput("start_bit", {31'd0, cap_start}, 32'd0);
          checkOutput("stop_bit", {31'd0, cap_stop}, 32'd1);
        end
      end
    end
  end

  task automatic checkReleasedIdle(input string tag);
    checkOutput({tag, "_idle"}, {31'd0, tx_idle}, 32'd1);
    checkOutput({tag, "_ps2c"}, {31'd0, ps2c}, 32'd1);
    checkOutput({tag, "_ps2d"}, {31'd0, ps2d}, 32'd1);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no end of test, expected finish within 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lf;
    int t;
    int busy;
    reset = 1'b1; wr_ps2 = 1'b0; din = 8'h00;
    dev_c_low = 1'b0; dev_d_low = 1'b0;
    cap_byte = 8'h00; cap_par = 1'b0; cap_start = 1'b1; cap_stop = 1'b0;
    repeat (3) @(negedge clk);
    checkReleasedIdle("reset");
    checkOutput("reset_done", {31'd0, tx_done_tick}, 32'd0);
    checkOutput("reset_err", {31'd0, tx_err_tick}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Acknowledged frames: bytes with hand-computed odd parity.
    applyStimulus(CMD_ENABLE, 1, 0, 1, 1'b0);
    deviceFrame(11, 1, 0, lf);
    repeat (20) @(negedge clk);
    checkReleasedIdle("f4_after");
    applyStimulus(8'h00, 1, 0, 1, 1'b1);
    deviceFrame(11, 1, 0, lf);
    repeat (20) @(negedge clk);
    applyStimulus(CMD_RESET, 1, 0, 1, 1'b1);
    deviceFrame(11, 1, 0, lf);
    repeat (20) @(negedge clk);

    // Write request held high throughout a frame, including the return to IDLE.
    applyStimulus(8'h01, 1, 0, 1, 1'b0);
    fork
      deviceFrame(11, 1, 0, lf);
      begin
        repeat (5) @(negedge clk);
        din = 8'h77;
        wr_ps2 = 1'b1;
        t = 0;
        while (!(tx_done_tick || tx_err_tick) && t < 3000) begin
          @(negedge clk);
          t++;
        end
        wr_ps2 = 1'b0;
      end
    join
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx_idle || ps2c !== 1'b1) busy++;
    end
    checkOutput("held_wr_ignored", busy, 0);

    // Missing acknowledge.
    applyStimulus(8'h5A, 1, 1, 1, 1'b1);
    deviceFrame(11, 0, 0, lf);
    repeat (20) @(negedge clk);
    checkReleasedIdle("noack_after");

    // Short low glitch on the device clock inside DATA must not shift a bit.
    applyStimulus(CMD_ENABLE, 1, 0, 1, 1'b0);
    deviceFrame(11, 1, 5, lf);
    repeat (20) @(negedge clk);

    // Second write during RTS is dropped; rts_len inside the device checks one inhibit.
    applyStimulus(8'h80, 1, 0, 1, 1'b0);
    fork
      deviceFrame(11, 1, 0, lf);
      begin
        repeat (20) @(negedge clk);
        din = 8'h55;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!tx_idle) busy++;
    end
    checkOutput("no_queued_write", busy, 0);

    // Device stops after four clocks: the clear happens TICK_LAT cycles after the fall.
    applyStimulus(8'h3C, 1, 1, 0, 1'b0);
    deviceFrame(4, 0, 0, lf);
    t = 0;
    while (!tx_err_tick && t < 6000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("timeout_cycle", cyc, lf + TICK_LAT + TO);
    @(negedge clk);
    checkReleasedIdle("timeout_after");
    repeat (20) @(negedge clk);

    // Reset in the middle of DATA while a zero bit is driven.
    applyStimulus(8'hA5, 0, 0, 0, 1'b0);
    deviceFrame(4, 0, 0, lf);
    checkOutput("mid_data_drive", {31'd0, ps2d}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkReleasedIdle("reset_data");
    reset = 1'b0;
    repeat (200) @(negedge clk);
    checkReleasedIdle("reset_data_later");

    // Reset while inhibiting the clock.
    applyStimulus(CMD_ENABLE, 0, 0, 0, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("rts_drive", {31'd0, ps2c}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkReleasedIdle("reset_rts");
    reset = 1'b0;
    repeat (300) @(negedge clk);
    checkReleasedIdle("reset_rts_later");

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000; clock-low inhibit time in clk cycles (100 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000; the longest gap in clk cycles between device clock edges before aborting (20 ms).
REQ-003 SHALL have parameter FILTER_LEN, default 8; the number of consecutive equal ps2c samples needed to accept a new level.
REQ-004 clk  input  1  single system clock, 100 MHz master clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 din  input  8  command byte to send, sampled when wr_ps2 is accepted.
REQ-007 wr_ps2  input  1  one-cycle request to start a transmission.
REQ-008 ps2c  inout  1  PS/2 clock line, open-drain: driven 0 or released (Z), never driven 1.
REQ-009 ps2d  inout  1  PS/2 data line, open-drain: driven 0 or released (Z), never driven 1.
REQ-010 tx_idle  output  1  high when in IDLE; the PS/2 receiver is enabled only while this is high.
REQ-011 tx_done_tick  output  1  one-cycle pulse when the device acknowledges the frame.
REQ-012 tx_err_tick  output  1  one-cycle pulse on a missing acknowledge or a timeout.

Function
REQ-013 ps2c and ps2d SHALL each pass through a 2-FF synchronizer; ps2c SHALL also pass through a FILTER_LEN glitch filter, and a falling edge SHALL be a 1-cycle pulse, fall_tick, from the filtered level.
REQ-014 States: IDLE, RTS, START, DATA, STOP.
REQ-015 IDLE: both lines released; tx_idle=1; wr_ps2=1 latches {odd_parity(din), din} into a 9-bit shift register, clears the counter, and goes to RTS.
REQ-016 Odd parity: the parity bit is 1 when din has an even number of ones, 0 otherwise.
REQ-017 RTS: ps2c driven 0, ps2d released; after INHIBIT_CYCLES cycles, go to START.
REQ-018 START: ps2c released, ps2d driven 0 (start bit); on fall_tick, go to DATA with bit counter = 8.
REQ-019 DATA: ps2d driven 0 when shift[0]=0 and released when shift[0]=1; on fall_tick, shift right; after the 9th DATA fall_tick (data bits LSB first, then parity), go to STOP.
REQ-020 STOP: ps2d released; on fall_tick, sample synchronized ps2d: 0 pulses tx_done_tick, 1 pulses tx_err_tick; either way go to IDLE.
REQ-021 In START, DATA and STOP, the counter SHALL clear on each fall_tick and otherwise increment; reaching TIMEOUT_CYCLES releases both lines, pulses tx_err_tick and returns to IDLE.
REQ-022 A frame consumes exactly 11 device falling edges after RTS.
REQ-023 wr_ps2 asserted outside IDLE SHALL be ignored, with no queuing.
REQ-024 wr_ps2 in the cycle the FSM returns to IDLE SHALL be ignored; it is accepted only while already in IDLE.
REQ-025 tx_done_tick and tx_err_tick SHALL never assert in the same cycle.
REQ-026 Line-drive enables SHALL be registered outputs of the FSM, with no combinational glitches on ps2c or ps2d.
REQ-027 Counter width SHALL hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES): 21 bits at the defaults.

Reset
REQ-028 On reset: state IDLE, both lines released, tx_idle=1, tx_done_tick=0, tx_err_tick=0, counter, shift register and bit counter 0, filter and synchronizers preset to 1.
REQ-029 Reset mid-frame, including in RTS, SHALL release both lines on the next clk edge, with no done or error pulse.

Structure
REQ-030 A shared package ps2_pkg SHALL hold the state enum, default INHIBIT_CYCLES/TIMEOUT_CYCLES/FILTER_LEN, and the command constants CMD_ENABLE=8'hF4 and CMD_RESET=8'hFF.
REQ-031 A sub-module ps2_filter (synchronizer, glitch filter, fall_tick) SHALL be instantiated once, and SHALL be reusable by the receiver.

Verification
REQ-032 Benches SHALL use INHIBIT_CYCLES=100 and TIMEOUT_CYCLES=5000, with a device model clocking at 12.5 kHz-equivalent scaled periods.
REQ-033 din=8'hF4, wr_ps2, device ack low on edge 11 -> bits 0,0,1,0,1,1,1,1, parity 0, stop released, tx_done_tick once, tx_idle=1 after.
REQ-034 din=8'h00 -> parity bit 1; din=8'hFF -> parity bit 1; din=8'h01 -> parity bit 0.
REQ-035 Device leaves ps2d high on edge 11 -> tx_err_tick once, no tx_done_tick.
REQ-036 Device stops clocking after edge 4 -> tx_err_tick exactly 5000 cycles after the last fall_tick, both lines released.
REQ-037 Reset mid-DATA, and a second wr_ps2 during RTS -> immediate release, IDLE, no ticks; the second write is ignored and ps2c is held low for only one inhibit period.
REQ-038 Inject a 3-cycle low glitch on ps2c during DATA -> no fall_tick, bit position unchanged.
